// File: rtl/serial_add_sequencer_if.sv
// Bundle of the sequencer's request/result signals and its full-adder bit lanes.
// No latency of its own; it only carries wires between the blocks.
// No backpressure: start is only sampled in IDLE, and results are held until the next accepted start.
interface serial_add_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    // Requester side. It also models the external full-adder cell.
    modport master (
        output start, op_a, op_b, cin, fa_sum, fa_cout,
        input  fa_a, fa_b, fa_cin, busy, done, result, cout
    );

    // Sequencer side.
    modport slave (
        input  start, op_a, op_b, cin, fa_sum, fa_cout,
        output fa_a, fa_b, fa_cin, busy, done, result, cout
    );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder sequencer: feeds an external 1-bit full adder LSB first and collects the sum bits.
// Latency: start accepted at edge k gives done in the cycle after edge k+WIDTH; next start is accepted at k+WIDTH+2 at the earliest.
// Backpressure: start is ignored while busy; result/cout are held until the next accepted start.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_add_sequencer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;

    // State register. Reset is synchronous and overrides an operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
        end
    end

    // Next state: capture on start, shift one bit per RUN cycle, and finish after WIDTH bits.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.op_a;
                    b_sh_d   = bus.op_b;
                    carry_d  = bus.cin;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // The new sum bit enters at the MSB. After WIDTH shifts, bit i sits at position i.
                result_d = {bus.fa_sum, result_q[WIDTH-1:1]};
                carry_d  = bus.fa_cout;
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    cout_d  = bus.fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs. The adder lanes are quiet outside RUN, so the cell sees zeros when idle.
    always_comb begin
        bus.fa_a   = (state_q == RUN) ? a_sh_q[0] : 1'b0;
        bus.fa_b   = (state_q == RUN) ? b_sh_q[0] : 1'b0;
        bus.fa_cin = (state_q == RUN) ? carry_q   : 1'b0;
        bus.busy   = (state_q == RUN) || (state_q == DONE);
        bus.done   = (state_q == DONE);
        bus.result = result_q;
        bus.cout   = cout_q;
    end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer at WIDTH=8 and WIDTH=4, with a behavioural full-adder cell.
// An arithmetic model is compared against both instances every cycle; directed tests pin known results.
// Stimulus changes 2 time units after each rising edge; outputs are sampled 1 time unit after it.
module tb_serial_add_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_add_sequencer_if #(.WIDTH(8)) if8 ();
    serial_add_sequencer_if #(.WIDTH(4)) if4 ();

    serial_add_sequencer #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_add_sequencer #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    // External full-adder cells.
    assign if8.fa_sum  = if8.fa_a ^ if8.fa_b ^ if8.fa_cin;
    assign if8.fa_cout = (if8.fa_a & if8.fa_b) | (if8.fa_cin & (if8.fa_a ^ if8.fa_b));
    assign if4.fa_sum  = if4.fa_a ^ if4.fa_b ^ if4.fa_cin;
    assign if4.fa_cout = (if4.fa_a & if4.fa_b) | (if4.fa_cin & (if4.fa_a ^ if4.fa_b));

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = WIDTH 8, 1 = WIDTH 4.
    // The model tracks an operation as "t bits done since acceptance".
    int W [2] = '{8, 4};
    bit m_act [2];
    bit m_dn  [2];
    int m_t   [2];
    int m_a   [2];
    int m_b   [2];
    int m_c   [2];
    int m_res [2];
    int m_cout[2];
    int m_ops [2];

    function automatic void step(int d, logic r, logic st, int a, int b, logic c);
        int mask;
        int s;
        mask = (1 << W[d]) - 1;
        if (r !== 1'b1) begin
            m_act[d] = 0; m_dn[d] = 0; m_t[d] = 0; m_res[d] = 0; m_cout[d] = 0;
        end else if (m_act[d]) begin
            m_t[d]++;
            if (m_t[d] == W[d]) begin
                s = m_a[d] + m_b[d] + m_c[d];
                m_act[d]  = 0;
                m_dn[d]   = 1;
                m_res[d]  = s & mask;
                m_cout[d] = (s >> W[d]) & 1;
                m_ops[d]++;
            end
        end else if (m_dn[d]) begin
            m_dn[d] = 0;
        end else if (st === 1'b1) begin
            m_act[d] = 1; m_t[d] = 0;
            m_a[d] = a & mask; m_b[d] = b & mask; m_c[d] = (c === 1'b1) ? 1 : 0;
            m_res[d] = 0; m_cout[d] = 0;
        end
    endfunction

    // Expected vector {busy, done, fa_a, fa_b, fa_cin, cout, result[15:0]}.
    function automatic logic [21:0] expect_vec(int d);
        int mask, m, s, i;
        logic [21:0] v;
        mask = (1 << W[d]) - 1;
        v = '0;
        v[21] = m_act[d] | m_dn[d];
        v[20] = m_dn[d];
        if (m_act[d]) begin
            i = m_t[d];
            m = (1 << i) - 1;
            s = m_a[d] + m_b[d] + m_c[d];
            v[19] = 1'((m_a[d] >> i) & 1);
            v[18] = 1'((m_b[d] >> i) & 1);
            v[17] = 1'((((m_a[d] & m) + (m_b[d] & m) + m_c[d]) >> i) & 1);
            v[16] = 1'b0;
            v[15:0] = 16'(((s & m) << (W[d] - i)) & mask);
        end else begin
            v[16] = 1'(m_cout[d]);
            v[15:0] = 16'(m_res[d]);
        end
        return v;
    endfunction

    task automatic cmp_vec(int d, logic [21:0] act);
        logic [21:0] ex;
        ex = expect_vec(d);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL model_w%0d t=%0t got busy/done/a/b/cin/cout/result=%b_%b_%b_%b_%b_%b_%h want %b_%b_%b_%b_%b_%b_%h",
                     W[d], $time, act[21], act[20], act[19], act[18], act[17], act[16], act[15:0],
                     ex[21], ex[20], ex[19], ex[18], ex[17], ex[16], ex[15:0]);
        end
    endtask

    // Single compare process: update the model on the edge, then check both instances just after it.
    always @(posedge clk) begin
        step(0, rst_n, if8.start, int'(if8.op_a), int'(if8.op_b), if8.cin);
        step(1, rst_n, if4.start, int'(if4.op_a), int'(if4.op_b), if4.cin);
        #1;
        cmp_vec(0, {if8.busy, if8.done, if8.fa_a, if8.fa_b, if8.fa_cin, if8.cout, 16'(if8.result)});
        cmp_vec(1, {if4.busy, if4.done, if4.fa_a, if4.fa_b, if4.fa_cin, if4.cout, 16'(if4.result)});
    end

    task automatic lit(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Start one WIDTH-8 operation, record fa_a per RUN cycle, then check the literal result at done.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] want_res, input logic want_cout, input string name,
                       output logic [7:0] seq);
        int n;
        if8.op_a = a; if8.op_b = b; if8.cin = c; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seq[i] = if8.fa_a;
            tick();
        end
        n = 0;
        while (if8.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        lit({name, "_done_latency"}, n, 0);
        lit({name, "_result"}, if8.result, want_res);
        lit({name, "_cout"}, if8.cout, want_cout);
        tick();
    endtask

    initial begin
        logic [7:0] seq;
        int n, dones, cyc;
        int t8 [$];
        int t4 [$];

        rst_n = 1'b0;
        if8.start = 1'b0; if8.op_a = '0; if8.op_b = '0; if8.cin = 1'b0;
        if4.start = 1'b0; if4.op_a = '0; if4.op_b = '0; if4.cin = 1'b0;
        tick();
        tick();
        lit("reset_result", if8.result, 0);
        lit("reset_busy", {if8.busy, if8.done, if8.fa_a, if8.fa_b, if8.fa_cin, if8.cout}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        lit("idle_hold", {if8.busy, if8.done, if8.cout, if8.result}, 0);

        // Basic addition and the fa_a bit order.
        op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c", seq);
        lit("fa_a_sequence", seq, 8'h5A);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ripple_ff_01", seq);
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ripple_ff_ff_c1", seq);
        lit("held_result_idle", if8.result, 8'hFF);

        // A second start while busy is ignored.
        if8.op_a = 8'h12; if8.op_b = 8'h34; if8.cin = 1'b0; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        tick(); tick();
        if8.op_a = 8'hFF; if8.op_b = 8'hFF; if8.cin = 1'b1; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (if8.done === 1'b1) begin
                dones++;
                lit("busy_start_result", if8.result, 8'h46);
                lit("busy_start_cout", if8.cout, 0);
            end
            tick();
        end
        lit("busy_start_done_count", dones, 1);

        // Reset in the middle of RUN discards the operation.
        if8.op_a = 8'hAA; if8.op_b = 8'h55; if8.cin = 1'b1; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        lit("midrun_reset_state", {if8.busy, if8.done, if8.cout, if8.result}, 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (if8.done === 1'b1) dones++;
            tick();
        end
        lit("midrun_reset_no_done", dones, 0);
        op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_reset_1_1", seq);

        // With start held high, a new operation is accepted every WIDTH+2 cycles.
        if8.start = 1'b1; if4.start = 1'b1;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (if8.done === 1'b1) t8.push_back(cyc);
            if (if4.done === 1'b1) t4.push_back(cyc);
            tick();
        end
        if8.start = 1'b0; if4.start = 1'b0;
        lit("b2b_w8_count", t8.size() >= 3, 1);
        lit("b2b_w4_count", t4.size() >= 3, 1);
        if (t8.size() >= 3) begin
            lit("b2b_w8_interval", t8[1] - t8[0], 10);
            lit("b2b_w8_interval2", t8[2] - t8[1], 10);
        end
        if (t4.size() >= 3) lit("b2b_w4_interval", t4[1] - t4[0], 6);
        for (int i = 0; i < 12; i++) tick();

        // Random traffic on both widths, including occasional resets.
        m_ops[0] = 0; m_ops[1] = 0;
        n = 0;
        while ((m_ops[0] < 1000 || m_ops[1] < 1000) && n < 60000) begin
            if8.start = ($urandom_range(0, 3) != 0);
            if8.op_a = 8'($urandom); if8.op_b = 8'($urandom); if8.cin = 1'($urandom);
            if4.start = ($urandom_range(0, 3) != 0);
            if4.op_a = 4'($urandom); if4.op_b = 4'($urandom); if4.cin = 1'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
            n++;
        end
        rst_n = 1'b1;
        if8.start = 1'b0; if4.start = 1'b0;
        lit("random_ops_w8_reached", m_ops[0] >= 1000, 1);
        lit("random_ops_w4_reached", m_ops[1] >= 1000, 1);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
